// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file sequencer.
package regfile_pkg;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        OP_LOADI   = 2'b00,
        OP_MOV     = 2'b01,
        OP_ALU     = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Only ALU operations need the second read port.
    function automatic logic op_reads_b(input op_t op);
        return (op == OP_ALU);
    endfunction

endpackage

// File: rtl/regfile_sequencer_exec_timer.sv
// Counts EXEC cycles and flags the last cycle in which AluDone may still arrive.
module exec_timer
    import regfile_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_r;

    // Cycle counter, saturating on the final permitted EXEC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable && !expired) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == LAST);

endmodule

// File: rtl/regfile_sequencer.sv
// Sequences LOADI / MOV / ALU operations over a two-read, one-write register file.
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       CLKb,
    input  logic       Rstb,
    input  logic       Start,
    input  logic [1:0] Op,
    input  logic [1:0] SrcA,
    input  logic [1:0] SrcB,
    input  logic [1:0] Dst,
    input  logic [9:0] Imm,
    input  logic [9:0] Q0,
    input  logic [9:0] Q1,
    input  logic [9:0] AluResult,
    input  logic       AluDone,
    output logic [9:0] D,
    output logic       ENW,
    output logic [1:0] WRA,
    output logic       ENR0,
    output logic       ENR1,
    output logic [1:0] RDA0,
    output logic [1:0] RDA1,
    output logic [9:0] OpA,
    output logic [9:0] OpB,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    state_t     state_r, state_nxt_s;
    op_t        op_r, op_cap_s;
    logic [1:0] srca_r, srcb_r, dst_r;
    logic [9:0] imm_r, result_r, opa_r, opb_r, d_s;
    logic       enw_r, enr0_r, enr1_r, busy_r, done_r, err_r;
    logic       enw_nxt_s, enr0_nxt_s, enr1_nxt_s, busy_nxt_s, done_nxt_s, err_s;
    logic       timer_en_s, timer_clr_s, expired_s;

    assign timer_en_s  = (state_r == S_EXEC);
    assign timer_clr_s = !timer_en_s;

    exec_timer #(.TIMEOUT(TIMEOUT)) u_exec_timer (
        .clk     (CLKb),
        .rst_n   (Rstb),
        .clear   (timer_clr_s),
        .enable  (timer_en_s),
        .expired (expired_s)
    );

    // State register
    always_ff @(posedge CLKb or negedge Rstb) begin
        if (!Rstb) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an illegal op or an ALU timeout raises the error strobe
    always_comb begin
        state_nxt_s = state_r;
        err_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (Start) begin
                    case (op_t'(Op))
                        OP_LOADI: state_nxt_s = S_WRITE;
                        OP_MOV:   state_nxt_s = S_READ;
                        OP_ALU:   state_nxt_s = S_READ;
                        default:  err_s       = 1'b1;
                    endcase
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_READ: begin
                if (op_r == OP_ALU) begin
                    state_nxt_s = S_EXEC;
                end else begin
                    state_nxt_s = S_WRITE;
                end
            end
            S_EXEC: begin
                if (AluDone) begin
                    state_nxt_s = S_WRITE;
                end else if (expired_s) begin
                    state_nxt_s = S_IDLE;
                    err_s       = 1'b1;
                end else begin
                    state_nxt_s = S_EXEC;
                end
            end
            S_WRITE: state_nxt_s = S_DONE;
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Control strobes for the coming state; the op is still on the inputs when leaving IDLE
    always_comb begin
        if (state_r == S_IDLE) begin
            op_cap_s = op_t'(Op);
        end else begin
            op_cap_s = op_r;
        end
        enw_nxt_s  = (state_nxt_s == S_WRITE);
        enr0_nxt_s = (state_nxt_s == S_READ);
        enr1_nxt_s = (state_nxt_s == S_READ) && op_reads_b(op_cap_s);
        busy_nxt_s = (state_nxt_s != S_IDLE);
        done_nxt_s = (state_nxt_s == S_DONE);
    end

    // Registered control outputs
    always_ff @(posedge CLKb or negedge Rstb) begin
        if (!Rstb) begin
            enw_r  <= 1'b0;
            enr0_r <= 1'b0;
            enr1_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            enw_r  <= enw_nxt_s;
            enr0_r <= enr0_nxt_s;
            enr1_r <= enr1_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            err_r  <= err_s;
        end
    end

    // Request capture, only on an accepted Start in IDLE
    always_ff @(posedge CLKb or negedge Rstb) begin
        if (!Rstb) begin
            op_r   <= OP_LOADI;
            srca_r <= 2'b00;
            srcb_r <= 2'b00;
            dst_r  <= 2'b00;
            imm_r  <= 10'h000;
        end else if ((state_r == S_IDLE) && Start) begin
            op_r   <= op_t'(Op);
            srca_r <= SrcA;
            srcb_r <= SrcB;
            dst_r  <= Dst;
            imm_r  <= Imm;
        end else begin
            op_r   <= op_r;
            srca_r <= srca_r;
            srcb_r <= srcb_r;
            dst_r  <= dst_r;
            imm_r  <= imm_r;
        end
    end

    // Operand latch on the edge leaving READ, ALU result latch on an accepted AluDone
    always_ff @(posedge CLKb or negedge Rstb) begin
        if (!Rstb) begin
            opa_r    <= 10'h000;
            opb_r    <= 10'h000;
            result_r <= 10'h000;
        end else begin
            if (state_r == S_READ) begin
                opa_r <= Q0;
                if (op_reads_b(op_r)) begin
                    opb_r <= Q1;
                end else begin
                    opb_r <= opb_r;
                end
            end else begin
                opa_r <= opa_r;
                opb_r <= opb_r;
            end
            if ((state_r == S_EXEC) && AluDone) begin
                result_r <= AluResult;
            end else begin
                result_r <= result_r;
            end
        end
    end

    // Write data selected from captured registers, forced to zero outside WRITE
    always_comb begin
        d_s = 10'h000;
        if (enw_r) begin
            case (op_r)
                OP_LOADI: d_s = imm_r;
                OP_MOV:   d_s = opa_r;
                OP_ALU:   d_s = result_r;
                default:  d_s = 10'h000;
            endcase
        end else begin
            d_s = 10'h000;
        end
    end

    assign D    = d_s;
    assign ENW  = enw_r;
    assign WRA  = enw_r ? dst_r : 2'b00;
    assign ENR0 = enr0_r;
    assign ENR1 = enr1_r;
    assign RDA0 = enr0_r ? srca_r : 2'b00;
    assign RDA1 = enr1_r ? srcb_r : 2'b00;
    assign OpA  = opa_r;
    assign OpB  = opb_r;
    assign Busy = busy_r;
    assign Done = done_r;
    assign Err  = err_r;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed self-checking bench for regfile_sequencer.
module tb_regfile_sequencer;

    logic       CLKb, Rstb, Start, AluDone;
    logic [1:0] Op, SrcA, SrcB, Dst;
    logic [9:0] Imm, Q0, Q1, AluResult;
    logic [9:0] D, OpA, OpB;
    logic       ENW, ENR0, ENR1, Busy, Done, Err;
    logic [1:0] WRA, RDA0, RDA1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [5:0] ctl, exp_ctl;

    regfile_sequencer dut (
        .CLKb(CLKb), .Rstb(Rstb), .Start(Start), .Op(Op),
        .SrcA(SrcA), .SrcB(SrcB), .Dst(Dst), .Imm(Imm),
        .Q0(Q0), .Q1(Q1), .AluResult(AluResult), .AluDone(AluDone),
        .D(D), .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .ENR1(ENR1),
        .RDA0(RDA0), .RDA1(RDA1), .OpA(OpA), .OpB(OpB),
        .Busy(Busy), .Done(Done), .Err(Err)
    );

    initial CLKb = 1'b0;
    always #5 CLKb = ~CLKb;

    task automatic tick();
        @(posedge CLKb);
        #1;
    endtask

    task automatic test_reset();
        Rstb = 1'b0; Start = 1'b0; Op = 2'b00; SrcA = 2'b00; SrcB = 2'b00; Dst = 2'b00;
        Imm = 10'h000; Q0 = 10'h000; Q1 = 10'h000; AluResult = 10'h000; AluDone = 1'b0;
        #3;
        n_tests++;
        if ({D, ENW, WRA, ENR0, ENR1, RDA0, RDA1, OpA, OpB, Busy, Done, Err} !== 45'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {D, ENW, WRA, ENR0, ENR1, RDA0, RDA1, OpA, OpB, Busy, Done, Err});
        end
        tick();
        tick();
        Rstb = 1'b1;
        tick();
        n_tests++;
        if ({Busy, Done, Err, ENW} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected 0000", {Busy, Done, Err, ENW});
        end
    endtask

    task automatic test_loadi();
        Start = 1'b1; Op = 2'b00; Imm = 10'h2A5; Dst = 2'd2;
        for (int c = 1; c <= 3; c++) begin
            tick();
            Start = 1'b0;
            ctl     = {Busy, Done, Err, ENW, ENR0, ENR1};
            exp_ctl = {c <= 2, c == 2, 1'b0, c == 1, 1'b0, 1'b0};
            n_tests++;
            if (ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL loadi_ctl c%0d: got %b expected %b", c, ctl, exp_ctl);
            end
            if (c == 1) begin
                n_tests++;
                if ({WRA, D} !== {2'd2, 10'h2A5}) begin
                    n_fail++;
                    $display("FAIL loadi_write: got WRA=%0d D=%h expected WRA=2 D=2a5", WRA, D);
                end
            end
        end
    endtask

    task automatic test_mov();
        Start = 1'b1; Op = 2'b01; SrcA = 2'd1; Dst = 2'd3; Q0 = 10'h155;
        for (int c = 1; c <= 4; c++) begin
            tick();
            Start = 1'b0;
            ctl     = {Busy, Done, Err, ENW, ENR0, ENR1};
            exp_ctl = {c <= 3, c == 3, 1'b0, c == 2, c == 1, 1'b0};
            n_tests++;
            if (ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL mov_ctl c%0d: got %b expected %b", c, ctl, exp_ctl);
            end
            if (c == 1) begin
                n_tests++;
                if (RDA0 !== 2'd1) begin
                    n_fail++;
                    $display("FAIL mov_rda0: got %0d expected 1", RDA0);
                end
            end
            if (c == 2) begin
                n_tests++;
                if ({OpA, WRA, D} !== {10'h155, 2'd3, 10'h155}) begin
                    n_fail++;
                    $display("FAIL mov_write: got OpA=%h WRA=%0d D=%h expected 155/3/155", OpA, WRA, D);
                end
            end
        end
    endtask

    // Dst aliases SrcB; a spurious AluDone in READ and a Start while busy must be ignored
    task automatic test_alu();
        Start = 1'b1; Op = 2'b10; SrcA = 2'd0; SrcB = 2'd1; Dst = 2'd1;
        Q0 = 10'h011; Q1 = 10'h022;
        for (int c = 1; c <= 9; c++) begin
            tick();
            Start     = (c == 3);
            Op        = 2'b00;
            AluDone   = (c == 1) || (c == 5);
            AluResult = (c == 5) ? 10'h3FF : 10'h111;
            ctl       = {Busy, Done, Err, ENW, ENR0, ENR1};
            exp_ctl   = {c <= 7, c == 7, 1'b0, c == 6, c == 1, c == 1};
            n_tests++;
            if (ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL alu_ctl c%0d: got %b expected %b", c, ctl, exp_ctl);
            end
            if (c == 1) begin
                n_tests++;
                if ({RDA0, RDA1, OpA} !== {2'd0, 2'd1, 10'h155}) begin
                    n_fail++;
                    $display("FAIL alu_read: got RDA0=%0d RDA1=%0d OpA=%h expected 0/1/155", RDA0, RDA1, OpA);
                end
            end
            if (c == 2) begin
                n_tests++;
                if ({OpA, OpB} !== {10'h011, 10'h022}) begin
                    n_fail++;
                    $display("FAIL alu_operands: got %h/%h expected 011/022", OpA, OpB);
                end
            end
            if (c == 6) begin
                n_tests++;
                if ({WRA, D} !== {2'd1, 10'h3FF}) begin
                    n_fail++;
                    $display("FAIL alu_write: got WRA=%0d D=%h expected 1/3ff", WRA, D);
                end
            end
        end
        AluDone = 1'b0;
    endtask

    task automatic test_timeout();
        Start = 1'b1; Op = 2'b10; AluDone = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            tick();
            Start   = 1'b0;
            ctl     = {Busy, Done, Err, ENW, ENR0, ENR1};
            exp_ctl = {c <= 16, 1'b0, c == 17, 1'b0, c == 1, c == 1};
            n_tests++;
            if (ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL timeout_ctl c%0d: got %b expected %b", c, ctl, exp_ctl);
            end
        end
    endtask

    task automatic test_illegal_and_busy();
        Start = 1'b1; Op = 2'b11;
        for (int c = 1; c <= 3; c++) begin
            tick();
            Start   = 1'b0;
            ctl     = {Busy, Done, Err, ENW, ENR0, ENR1};
            exp_ctl = {1'b0, 1'b0, c == 1, 1'b0, 1'b0, 1'b0};
            n_tests++;
            if (ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL illegal_ctl c%0d: got %b expected %b", c, ctl, exp_ctl);
            end
        end
        Start = 1'b1; Op = 2'b00; Imm = 10'h0AA; Dst = 2'd0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            Start   = (c <= 1);
            Op      = 2'b01;
            ctl     = {Busy, Done, Err, ENW, ENR0, ENR1};
            exp_ctl = {c <= 2, c == 2, 1'b0, c == 1, 1'b0, 1'b0};
            n_tests++;
            if (ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL busy_ignore c%0d: got %b expected %b", c, ctl, exp_ctl);
            end
        end
    endtask

    task automatic test_reset_in_write();
        Start = 1'b1; Op = 2'b00; Imm = 10'h1C3; Dst = 2'd2;
        tick();
        Start = 1'b0;
        n_tests++;
        if ({ENW, D} !== {1'b1, 10'h1C3}) begin
            n_fail++;
            $display("FAIL rstw_pre: got ENW=%b D=%h expected 1/1c3", ENW, D);
        end
        #2;
        Rstb = 1'b0;
        #1;
        n_tests++;
        if ({ENW, D, WRA, Busy, Done, Err, OpA, OpB} !== 36'd0) begin
            n_fail++;
            $display("FAIL rstw_async: got %h expected 0", {ENW, D, WRA, Busy, Done, Err, OpA, OpB});
        end
        tick();
        Rstb = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_tests++;
            if ({Busy, Done, ENW} !== 3'b000) begin
                n_fail++;
                $display("FAIL rstw_idle c%0d: got %b expected 000", c, {Busy, Done, ENW});
            end
        end
    endtask

    initial begin
        test_reset();
        test_loadi();
        test_mov();
        test_alu();
        test_timeout();
        test_illegal_and_busy();
        test_reset_in_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum EXEC wait in cycles before an ALU timeout.
REQ-002 CLKb  in  1  debounced clock; all state SHALL update on its rising edge.
REQ-003 Rstb  in  1  asynchronous active-low reset.
REQ-004 Start  in  1  request strobe, sampled only in IDLE.
REQ-005 Op  in  2  operation: 00 LOADI, 01 MOV, 10 ALU, 11 illegal.
REQ-006 SrcA, SrcB, Dst  in  2 each  source and destination register addresses.
REQ-007 Imm  in  10  immediate for LOADI.
REQ-008 Q0, Q1  in  10 each  register-file read data.
REQ-009 AluResult  in  10  ALU result; AluDone  in  1  result-valid strobe.
REQ-010 D  out  10  write data; ENW  out  1  write enable; WRA  out  2  write address.
REQ-011 ENR0, ENR1  out  1 each  read enables; RDA0, RDA1  out  2 each  read addresses.
REQ-012 OpA, OpB  out  10 each  latched operands to the ALU.
REQ-013 Busy  out  1  high in any state except IDLE.
REQ-014 Done, Err  out  1 each  single-cycle completion and error pulses.

Function
REQ-015 States SHALL be IDLE, READ, EXEC, WRITE, DONE.
REQ-016 In IDLE with Start=1, Op, SrcA, SrcB, Dst, Imm SHALL be captured into internal registers on that edge.
REQ-017 Transitions: LOADI IDLE->WRITE; MOV IDLE->READ->WRITE; ALU IDLE->READ->EXEC->WRITE; all WRITE->DONE->IDLE.
REQ-018 Op=11 SHALL stay in IDLE, pulse Err one cycle after the Start edge, and perform no read or write.
REQ-019 READ SHALL last exactly one cycle with ENR0=1, RDA0=SrcA; ENR1=1, RDA1=SrcB only for ALU; otherwise ENR0/ENR1=0.
REQ-020 OpA<=Q0 (and OpB<=Q1 for ALU) SHALL be latched on the edge leaving READ; OpA/OpB SHALL hold otherwise.
REQ-021 EXEC SHALL wait for AluDone=1, capturing AluResult on that edge and moving to WRITE; minimum one EXEC cycle.
REQ-022 If AluDone is not seen within TIMEOUT EXEC cycles, the block SHALL pulse Err, skip WRITE, and return to IDLE.
REQ-023 WRITE SHALL last exactly one cycle with ENW=1, WRA=Dst, D=Imm (LOADI), OpA (MOV) or captured result (ALU).
REQ-024 ENW SHALL be 0 in every state except WRITE; ENR0/ENR1 SHALL be 0 outside READ.
REQ-025 Done SHALL be 1 only in DONE; Start while Busy=1 SHALL be ignored, not queued.
REQ-026 Latency Start edge to Done high: LOADI 2 cycles, MOV 3, ALU 3+N where N = EXEC cycles.
REQ-027 Dst equal to SrcA/SrcB SHALL be legal; read precedes write, so old value is used.
REQ-028 AluDone outside EXEC SHALL be ignored.

Reset
REQ-029 Rstb=0 SHALL immediately force IDLE and drive ENW, ENR0, ENR1, Busy, Done, Err to 0, and D, WRA, RDA0, RDA1, OpA, OpB, timer to 0.
REQ-030 Reset asserted during WRITE SHALL deassert ENW asynchronously; no register-file write SHALL complete.
REQ-031 After Rstb rises, the first Start SHALL be accepted no earlier than the next rising CLKb edge.

Structure
REQ-032 A shared package regfile_pkg SHALL hold the op enum, the state enum, and the default TIMEOUT constant.
REQ-033 The EXEC timeout SHALL be a sub-module exec_timer (clear, enable, expired output, width from TIMEOUT).
REQ-034 Outputs SHALL be registered or decoded from the state register only; no combinational path from Q0/Q1 to ENW.

Verification
REQ-035 LOADI Imm=10'h2A5, Dst=2 -> ENW=1, WRA=2, D=10'h2A5 for one cycle; Done two cycles after Start.
REQ-036 MOV SrcA=1, Dst=3, Q0=10'h155 in READ -> OpA=10'h155; WRITE D=10'h155, WRA=3; Done at cycle 3.
REQ-037 ALU SrcA=0, SrcB=1, AluDone after 4 EXEC cycles with AluResult=10'h3FF -> WRITE D=10'h3FF; Done at cycle 7.
REQ-038 ALU with AluDone held low -> Err pulse after 15 EXEC cycles; ENW never asserted; Busy falls.
REQ-039 Op=11 -> Err one cycle later; ENR0/ENR1/ENW stay 0; Start pulses during Busy produce no second op.
REQ-040 Rstb low during WRITE -> ENW drops without CLKb edge; all outputs zero; state IDLE.
